// File: rtl/bert_sync_pkg.sv
// Shared state encoding and default configuration values for the BERT sync controller.
package bert_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } sync_state_t;

  localparam int DEF_SEED_LENGTH  = 32;
  localparam int DEF_VERIFY_BITS  = 100;
  localparam int DEF_LOCK_THRESH  = 0;
  localparam int DEF_WINDOW_BITS  = 1000;
  localparam int DEF_LOSS_THRESH  = 5;
  localparam int DEF_LOSS_WINDOWS = 3;

endpackage

// File: rtl/bert_window_counter.sv
// Bit/error counter pair for one acquisition or measurement window; flags the window's last bit.
module bert_window_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             count,
  input  logic             error,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] err_total,
  output logic             last
);

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] limit_eff;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      bit_cnt <= '0;
      err_cnt <= '0;
    end else if (count) begin
      bit_cnt <= bit_cnt + 1'b1;
      err_cnt <= err_total;
    end
  end

  // err_total includes the current bit so the owner can judge a window on its final bit.
  always_comb begin
    limit_eff = (limit == '0) ? CNT_W'(1) : limit;
    err_total = (error && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
    last      = (bit_cnt >= limit_eff - 1'b1);
  end

endmodule

// File: rtl/bert_sync_controller.sv
// BERT pattern acquisition and lock-maintenance sequencer (IDLE -> SEED -> VERIFY -> LOCKED).
// Optional running totals are built when BERT_SYNC_TOTALS_EN is defined.
module bert_sync_controller
  import bert_sync_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int BAD_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
`ifdef BERT_SYNC_TOTALS_EN
  input  logic             totals_clear,
  output logic [31:0]      total_bits,
  output logic [31:0]      total_errors,
`endif
  input  logic             run,
  input  logic             enable,
  input  logic             error,
  input  logic             blackout,
  input  logic [CNT_W-1:0] seed_length,
  input  logic [CNT_W-1:0] verify_bits,
  input  logic [CNT_W-1:0] lock_thresh,
  input  logic [CNT_W-1:0] window_bits,
  input  logic [CNT_W-1:0] loss_thresh,
  input  logic [BAD_W-1:0] loss_windows,
  output logic             reload,
  output logic             lfsr_load,
  output logic             slip_enable,
  output logic             locked,
  output logic             lock_lost,
  output logic             window_done,
  output logic [CNT_W-1:0] window_errors
);

  sync_state_t      state, next_state;
  logic             bit_taken, cnt_error, cnt_clear, cnt_count, last;
  logic [CNT_W-1:0] limit, err_total, window_errors_d;
  logic [BAD_W-1:0] bad_cnt, bad_d, loss_eff;
  logic [BAD_W:0]   bad_inc;
  logic             reload_d, lock_lost_d, window_done_d;

  // Seeding shifts every strobe into the LFSR; only checked bits honour blackout and error.
  assign bit_taken = enable && ((state == SEED) || !blackout);
  assign cnt_error = error && (state != SEED);
  assign loss_eff  = (loss_windows == '0) ? BAD_W'(1) : loss_windows;
  assign bad_inc   = {1'b0, bad_cnt} + 1'b1;

  always_comb begin
    case (state)
      SEED:    limit = seed_length;
      VERIFY:  limit = verify_bits;
      default: limit = window_bits;
    endcase
  end

  bert_window_counter #(.CNT_W(CNT_W)) u_window (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (cnt_clear),
    .count     (cnt_count),
    .error     (cnt_error),
    .limit     (limit),
    .err_total (err_total),
    .last      (last)
  );

  always_comb begin
    // NOTE: defaults first keep every path assigned, so no latch is inferred.
    next_state      = state;
    cnt_clear       = 1'b0;
    cnt_count       = 1'b0;
    reload_d        = 1'b0;
    lock_lost_d     = 1'b0;
    window_done_d   = 1'b0;
    window_errors_d = window_errors;
    bad_d           = bad_cnt;
    if (!run) begin
      next_state      = IDLE;
      cnt_clear       = 1'b1;
      bad_d           = '0;
      window_errors_d = '0;
    end else begin
      case (state)
        IDLE: begin
          next_state = SEED;
          reload_d   = 1'b1;
          cnt_clear  = 1'b1;
          bad_d      = '0;
        end
        SEED: if (bit_taken) begin
          if (last) begin
            next_state = VERIFY;
            cnt_clear  = 1'b1;
          end else begin
            cnt_count = 1'b1;
          end
        end
        VERIFY: if (bit_taken) begin
          // Too many errors abandons the seed even on the window's final bit.
          if (err_total > lock_thresh) begin
            next_state = SEED;
            reload_d   = 1'b1;
            cnt_clear  = 1'b1;
          end else if (last) begin
            next_state = LOCKED;
            cnt_clear  = 1'b1;
          end else begin
            cnt_count = 1'b1;
          end
        end
        LOCKED: if (bit_taken) begin
          if (last) begin
            cnt_clear       = 1'b1;
            window_done_d   = 1'b1;
            window_errors_d = err_total;
            if (err_total > loss_thresh) begin
              if (bad_inc >= {1'b0, loss_eff}) begin
                next_state  = SEED;
                lock_lost_d = 1'b1;
                reload_d    = 1'b1;
                bad_d       = '0;
              end else begin
                bad_d = bad_inc[BAD_W-1:0];
              end
            end else begin
              bad_d = '0;
            end
          end else begin
            cnt_count = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      bad_cnt       <= '0;
      reload        <= 1'b0;
      lfsr_load     <= 1'b0;
      slip_enable   <= 1'b0;
      locked        <= 1'b0;
      lock_lost     <= 1'b0;
      window_done   <= 1'b0;
      window_errors <= '0;
    end else begin
      state         <= next_state;
      bad_cnt       <= bad_d;
      reload        <= reload_d;
      lfsr_load     <= (next_state == SEED);
      slip_enable   <= (next_state == LOCKED);
      locked        <= (next_state == LOCKED);
      lock_lost     <= lock_lost_d;
      window_done   <= window_done_d;
      window_errors <= window_errors_d;
    end
  end

`ifdef BERT_SYNC_TOTALS_EN
  always_ff @(posedge clock) begin
    if (!reset_n || totals_clear) begin
      total_bits   <= '0;
      total_errors <= '0;
    end else if (run && (state == LOCKED) && bit_taken) begin
      if (total_bits != '1) total_bits <= total_bits + 1'b1;
      if (error && (total_errors != '1)) total_errors <= total_errors + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bert_sync_controller.sv
// Self-checking bench for bert_sync_controller: vector table, directed sequences, random vs model.
module tb_bert_sync_controller;

  localparam int CNT_W = 16;
  localparam int BAD_W = 4;

  logic             clock;
  logic             reset_n, run, enable, error, blackout;
  logic [CNT_W-1:0] seed_length, verify_bits, lock_thresh, window_bits, loss_thresh;
  logic [BAD_W-1:0] loss_windows;
  logic             reload, lfsr_load, slip_enable, locked, lock_lost, window_done;
  logic [CNT_W-1:0] window_errors;
`ifdef BERT_SYNC_TOTALS_EN
  logic             totals_clear;
  logic [31:0]      total_bits, total_errors;
`endif

  int n_vec = 0;
  int n_err = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bert_sync_controller #(.CNT_W(CNT_W), .BAD_W(BAD_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
`ifdef BERT_SYNC_TOTALS_EN
    .totals_clear  (totals_clear),
    .total_bits    (total_bits),
    .total_errors  (total_errors),
`endif
    .run           (run),
    .enable        (enable),
    .error         (error),
    .blackout      (blackout),
    .seed_length   (seed_length),
    .verify_bits   (verify_bits),
    .lock_thresh   (lock_thresh),
    .window_bits   (window_bits),
    .loss_thresh   (loss_thresh),
    .loss_windows  (loss_windows),
    .reload        (reload),
    .lfsr_load     (lfsr_load),
    .slip_enable   (slip_enable),
    .locked        (locked),
    .lock_lost     (lock_lost),
    .window_done   (window_done),
    .window_errors (window_errors)
  );

  typedef struct {
    logic        run, en, err, blk;
    logic        rl, ll, lk, wd, lost;
    logic [15:0] we;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input logic err, input logic blk);
    enable = 1'b1; error = err; blackout = blk;
    tick();
    enable = 1'b0; error = 1'b0; blackout = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic cfg(input int sl, input int vb, input int lt, input int wb, input int lst, input int lw);
    seed_length  = CNT_W'(sl);
    verify_bits  = CNT_W'(vb);
    lock_thresh  = CNT_W'(lt);
    window_bits  = CNT_W'(wb);
    loss_thresh  = CNT_W'(lst);
    loss_windows = BAD_W'(lw);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_reload"}, reload, 0);
    check({tag, "_lfsr_load"}, lfsr_load, 0);
    check({tag, "_slip_enable"}, slip_enable, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_lock_lost"}, lock_lost, 0);
    check({tag, "_window_done"}, window_done, 0);
    check({tag, "_window_errors"}, window_errors, 0);
  endtask

  function automatic vec_t mk(input logic r, en, er, bk, rl, ll, lk, wd, lost, input int we);
    vec_t v;
    v.run = r; v.en = en; v.err = er; v.blk = bk;
    v.rl = rl; v.ll = ll; v.lk = lk; v.wd = wd; v.lost = lost; v.we = 16'(we);
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef enum {PH_OFF, PH_ACQ, PH_CHK, PH_TRK} phase_t;
  phase_t ph;
  int m_bits, m_errs, m_bad;
  int e_werr;
  bit e_reload, e_lost, e_wdone;
  int unsigned m_tbits, m_terrs;

  function automatic int at_least_one(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit counted;
    counted  = enable && !blackout;
    e_reload = 0; e_lost = 0; e_wdone = 0;
    if (!reset_n) begin
      ph = PH_OFF; m_bits = 0; m_errs = 0; m_bad = 0; e_werr = 0;
      m_tbits = 0; m_terrs = 0;
    end else begin
`ifdef BERT_SYNC_TOTALS_EN
      if (totals_clear) begin
        m_tbits = 0; m_terrs = 0;
      end else if (ph == PH_TRK && run && counted) begin
        if (m_tbits != 32'hFFFF_FFFF) m_tbits++;
        if (error && m_terrs != 32'hFFFF_FFFF) m_terrs++;
      end
`endif
      if (!run) begin
        ph = PH_OFF; m_bits = 0; m_errs = 0; m_bad = 0; e_werr = 0;
      end else begin
        case (ph)
          PH_OFF: begin
            ph = PH_ACQ; e_reload = 1; m_bits = 0; m_errs = 0; m_bad = 0;
          end
          PH_ACQ: if (enable) begin
            m_bits++;
            if (m_bits >= at_least_one(int'(seed_length))) begin
              ph = PH_CHK; m_bits = 0; m_errs = 0;
            end
          end
          PH_CHK: if (counted) begin
            m_bits++;
            if (error && m_errs < 65535) m_errs++;
            if (m_errs > int'(lock_thresh)) begin
              ph = PH_ACQ; e_reload = 1; m_bits = 0; m_errs = 0;
            end else if (m_bits >= at_least_one(int'(verify_bits))) begin
              ph = PH_TRK; m_bits = 0; m_errs = 0;
            end
          end
          PH_TRK: if (counted) begin
            m_bits++;
            if (error && m_errs < 65535) m_errs++;
            if (m_bits >= at_least_one(int'(window_bits))) begin
              e_wdone = 1;
              e_werr  = m_errs;
              if (m_errs > int'(loss_thresh)) begin
                m_bad++;
                if (m_bad >= at_least_one(int'(loss_windows))) begin
                  ph = PH_ACQ; e_lost = 1; e_reload = 1; m_bad = 0;
                end
              end else begin
                m_bad = 0;
              end
              m_bits = 0; m_errs = 0;
            end
          end
          default: ph = PH_OFF;
        endcase
      end
    end
  endtask

  int n_lfsr, n_rl;
  int win_errs[6] = '{6, 6, 2, 6, 6, 6};

  initial begin
    reset_n = 1'b0; run = 1'b0; enable = 1'b0; error = 1'b0; blackout = 1'b0;
`ifdef BERT_SYNC_TOTALS_EN
    totals_clear = 1'b0;
`endif
    cfg(32, 100, 0, 50, 5, 3);
    tick();
    do_reset();
    check_idle("reset");

    // Acquisition from IDLE: one reload, 32 seed strobes, lock after strobe 132.
    run = 1'b1;
    tick();
    check("start_reload", reload, 1);
    n_lfsr = 0; n_rl = 0;
    for (int k = 1; k <= 132; k++) begin
      if (lfsr_load) n_lfsr++;
      strobe(1'b0, 1'b0);
      if (reload) n_rl++;
      if (k == 131) check("acq_locked_early", locked, 0);
    end
    check("acq_seed_strobes", n_lfsr, 32);
    check("acq_extra_reloads", n_rl, 0);
    check("acq_locked", locked, 1);
    check("acq_slip_enable", slip_enable, 1);

    // Locked window of 50 with errors on bits 5, 20 and the final bit.
    for (int k = 0; k < 50; k++) begin
      strobe(k == 5 || k == 20 || k == 49, 1'b0);
      if (k == 48) check("win_done_early", window_done, 0);
    end
    check("win_done", window_done, 1);
    check("win_errors", window_errors, 3);
    check("win_locked", locked, 1);
    tick();
    check("win_done_pulse", window_done, 0);
    check("win_errors_hold", window_errors, 3);

    // Bad/good window history 6,6,2,6,6,6 against loss_thresh 5, loss_windows 3.
    for (int w = 0; w < 6; w++) begin
      for (int k = 0; k < 50; k++) strobe(k < win_errs[w], 1'b0);
      check("loss_window_errors", window_errors, win_errs[w]);
      check("loss_window_done", window_done, 1);
      check("loss_locked", locked, (w < 5) ? 1 : 0);
      check("loss_lock_lost", lock_lost, (w < 5) ? 0 : 1);
      check("loss_reload", reload, (w < 5) ? 0 : 1);
    end
    check("loss_lfsr_load", lfsr_load, 1);
    tick();
    check("loss_lost_pulse", lock_lost, 0);

    // Relock, then a window with four blackout strobes carrying errors.
    for (int k = 0; k < 132; k++) strobe(1'b0, 1'b0);
    check("relock", locked, 1);
    for (int k = 0; k < 54; k++) begin
      strobe(k >= 10 && k <= 13, k >= 10 && k <= 13);
      if (k == 52) check("blk_done_early", window_done, 0);
    end
    check("blk_done", window_done, 1);
    check("blk_errors", window_errors, 0);
`ifdef BERT_SYNC_TOTALS_EN
    check("tot_bits", total_bits, 400);
    check("tot_errors", total_errors, 35);
`endif

    // run=0 while locked, then reset while verifying.
    run = 1'b0;
    tick();
    check_idle("stop");
    run = 1'b1;
    tick();
    check("restart_reload", reload, 1);
    for (int k = 0; k < 32; k++) strobe(1'b0, 1'b0);
    check("restart_verify", lfsr_load, 0);
    for (int k = 0; k < 20; k++) strobe(1'b0, 1'b0);
    reset_n = 1'b0;
    tick();
    check_idle("abort");
`ifdef BERT_SYNC_TOTALS_EN
    check("abort_tot_bits", total_bits, 0);
    check("abort_tot_errors", total_errors, 0);
`endif
    reset_n = 1'b1; run = 1'b0;
    tick();

    // Verify failure: lock_thresh 2, errors on verify bits 10, 20, 30.
    cfg(32, 100, 2, 50, 5, 3);
    run = 1'b1;
    tick();
    for (int k = 0; k < 32; k++) strobe(1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      strobe(k == 10 || k == 20 || k == 30, 1'b0);
      if (k == 29) begin
        check("vfail_lfsr_early", lfsr_load, 0);
        check("vfail_reload_early", reload, 0);
      end
    end
    check("vfail_reload", reload, 1);
    check("vfail_lfsr_load", lfsr_load, 1);
    check("vfail_locked", locked, 0);

    // Vector table with tiny windows: seed 2, verify 3, window 2, one bad window drops lock.
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    cfg(2, 3, 0, 2, 0, 1);
    do_reset();
    foreach (tbl[i]) begin
      run = tbl[i].run; enable = tbl[i].en; error = tbl[i].err; blackout = tbl[i].blk;
      tick();
      check("tbl_reload", reload, tbl[i].rl);
      check("tbl_lfsr_load", lfsr_load, tbl[i].ll);
      check("tbl_locked", locked, tbl[i].lk);
      check("tbl_window_done", window_done, tbl[i].wd);
      check("tbl_lock_lost", lock_lost, tbl[i].lost);
      check("tbl_window_errors", window_errors, tbl[i].we);
    end
    enable = 1'b0; error = 1'b0; blackout = 1'b0;

    // Randomised traffic against the reference model.
    cfg(3, 4, 1, 4, 1, 2);
    reset_n = 1'b0; run = 1'b0;
    model_step();
    tick();
    for (int c = 0; c < 3000; c++) begin
      reset_n  = ($urandom_range(0, 255) != 0);
      run      = ($urandom_range(0, 63) != 0);
      enable   = ($urandom_range(0, 3) != 0);
      error    = ($urandom_range(0, 5) == 0);
      blackout = ($urandom_range(0, 7) == 0);
`ifdef BERT_SYNC_TOTALS_EN
      totals_clear = ($urandom_range(0, 31) == 0);
`endif
      if ($urandom_range(0, 63) == 0)
        cfg($urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 2),
            $urandom_range(0, 6), $urandom_range(0, 2), $urandom_range(0, 3));
      model_step();
      tick();
      check("rnd_reload", reload, e_reload);
      check("rnd_lfsr_load", lfsr_load, ph == PH_ACQ);
      check("rnd_slip_enable", slip_enable, ph == PH_TRK);
      check("rnd_locked", locked, ph == PH_TRK);
      check("rnd_lock_lost", lock_lost, e_lost);
      check("rnd_window_done", window_done, e_wdone);
      check("rnd_window_errors", window_errors, e_werr);
`ifdef BERT_SYNC_TOTALS_EN
      check("rnd_total_bits", total_bits, m_tbits);
      check("rnd_total_errors", total_errors, m_terrs);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bert_sync_controller.md
Name: bert_sync_controller

Overview:
- Sequences BERT pattern acquisition and lock maintenance around the slip detector and the reference LFSR.
- Seeds the LFSR from received data, verifies the seed over a window, then declares lock.
- While locked, enables slip correction, measures the error count per window and declares loss of lock.
- Sits between the bit-strobe source, the LFSR/slip-detect datapath and the register interface.

Parameters:
CNT_W, 16, width of bit/error window counters and config fields
BAD_W, 4, width of consecutive-bad-window counter and loss_windows field

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
run  in  1  level; 0 forces IDLE
enable  in  1  bit strobe; one received bit per high cycle
error  in  1  data XOR reference code for the current bit (valid when enable)
blackout  in  1  slip-recovery blackout from slip detector; bit excluded from counts
seed_length  in  CNT_W  bits of received data shifted into the LFSR while seeding (0 treated as 1)
verify_bits  in  CNT_W  bits in the verify window (0 treated as 1)
lock_thresh  in  CNT_W  max errors allowed in the verify window
window_bits  in  CNT_W  bits per locked measurement window (0 treated as 1)
loss_thresh  in  CNT_W  window is bad when errors > loss_thresh
loss_windows  in  BAD_W  consecutive bad windows that drop lock (0 treated as 1)
reload  out  1  one-clock pulse to clear slip-detect counters
lfsr_load  out  1  LFSR takes received data instead of feedback
slip_enable  out  1  slip detector active
locked  out  1  lock status
lock_lost  out  1  one-clock pulse on the LOCKED->SEED transition
window_done  out  1  one-clock pulse at the end of each locked window
window_errors  out  CNT_W  error count of the last completed window

Behaviour:
- All outputs are registered. While reset_n=0, on a rising edge the block goes to IDLE and clears all counters and outputs to 0.
- IDLE: all outputs 0. run=1 moves the block to SEED on the next clock, with reload=1 in that same cycle.
- SEED: lfsr_load=1. Each enable increments bit_cnt.
  - The bit with bit_cnt == seed_length-1 moves the block to VERIFY on the next clock.
  - Clears bit_cnt and err_cnt.
- VERIFY: lfsr_load=0. Each enable with blackout=0 increments bit_cnt and, when error=1, increments err_cnt.
  - If err_cnt+error > lock_thresh: go to SEED, reload pulse, counters cleared. This takes priority over window end.
  - Else, on the bit_cnt == verify_bits-1 bit: go to LOCKED, counters cleared.
- LOCKED: locked=1 and slip_enable=1. Counting rules are the same as VERIFY.
  - On the last bit of the window (the error on that bit is included):
    - window_done=1 for one clock;
    - window_errors <= err_cnt+error;
    - counters cleared.
  - Bad window: increment bad_cnt. Good window: clear bad_cnt.
  - When bad_cnt reaches loss_windows: next state SEED, lock_lost=1, reload=1, locked=0, and window_done still pulses.
- run=0 in any state: IDLE next clock, with no reload and no lock_lost. The IDLE->SEED transition always pulses reload.
- err_cnt saturates at all-ones. bit_cnt cannot exceed its configured limit.
- Config inputs are sampled live. Changing them mid-window takes effect at the next compare.
- reset_n=0 mid-operation aborts with no pulses.
- enable=0 cycles hold all counters and state, except run=0, which is honoured regardless of enable.

Optional Feature:
BERT_SYNC_TOTALS_EN
- Defined: adds input totals_clear and outputs total_bits[31:0] and total_errors[31:0].
  - While locked, both count every counted bit/error. Both saturate.
  - totals_clear=1 zeroes them next clock and takes priority over increment.
  - Reset zeroes them.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package bert_sync_pkg: state encoding constants (IDLE=0, SEED=1, VERIFY=2, LOCKED=3) and default config constants.
- Sub-module bert_window_counter: bit/error counter pair with clear, saturation and window-end compare. Instantiated once and shared by VERIFY and LOCKED.

Test Plan:
1. run=1, seed_length=32, verify_bits=100, lock_thresh=0, error=0 -> reload once, lfsr_load for exactly 32 strobes, locked=1 on the clock after bit 132.
2. VERIFY with lock_thresh=2, errors injected on bits 10, 20, 30 -> return to SEED after bit 30 with a reload pulse, locked stays 0.
3. LOCKED, window_bits=50, 3 errors including the last bit -> window_done pulse, window_errors=3.
4. loss_thresh=5, loss_windows=3, windows with 6, 6, 2, 6, 6, 6 errors -> lock retained through the 5th window; lock_lost, reload and locked=0 after the 6th.
5. blackout=1 for 4 strobes carrying error=1 -> counts unchanged; window end delayed by 4 strobes.
6. run=0 mid-LOCKED, then reset_n=0 mid-VERIFY -> IDLE, all outputs 0, no lock_lost/reload pulses; totals (if enabled) zero after reset.
